// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Bus between the control unit and the iterative multiply/divide unit.
//
// Optional feature macro: MULTDIV_UNSIGNED_EN (adds the Unsgn request bit).
//
// Signals
//   Start    control -> unit  launch request, sampled only while the unit is idle
//   Op       control -> unit  0 = mult, 1 = div
//   A        control -> unit  multiplicand / dividend (rs)
//   B        control -> unit  multiplier / divisor (rt)
//   Unsgn    control -> unit  1 = multu/divu (only with MULTDIV_UNSIGNED_EN)
//   Hi       unit -> control  product upper half / remainder
//   Lo       unit -> control  product lower half / quotient
//   Busy     unit -> control  operation in flight
//   Done     unit -> control  one-cycle completion pulse
//   DivZero  unit -> control  one-cycle pulse with Done for a divide by zero
// Modports
//   master   the control unit side
//   slave    the multiply/divide unit side
// ----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef MULTDIV_UNSIGNED_EN
    logic             Unsgn;
`endif
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             DivZero;

`ifdef MULTDIV_UNSIGNED_EN
    modport master (
        output Start, Op, A, B, Unsgn,
        input  Hi, Lo, Busy, Done, DivZero
    );

    modport slave (
        input  Start, Op, A, B, Unsgn,
        output Hi, Lo, Busy, Done, DivZero
    );
`else
    modport master (
        output Start, Op, A, B,
        input  Hi, Lo, Busy, Done, DivZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Hi, Lo, Busy, Done, DivZero
    );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit sitting beside the datapath ALU (MIPS mult/div).
// Multiply uses radix-2 Booth recoding, divide uses restoring division on
// operand magnitudes with a sign fix-up at the end. One iteration per cycle,
// WIDTH iterations per operation; a divide by zero finishes immediately.
//
// Optional feature macro: MULTDIV_UNSIGNED_EN
//   defined   : bus.Unsgn is latched with Start and selects multu/divu
//   undefined : every operation is signed
//
// Ports
//   Clk      clock, all state updates on the rising edge
//   Reset    synchronous, active-high; aborts any operation and clears Hi/Lo
//   bus      mult_div_unit_if.slave: Start/Op/A/B(/Unsgn) in,
//            Hi/Lo/Busy/Done/DivZero out
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           Clk,
    input logic           Reset,
    mult_div_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             uns_q, uns_d;
    logic             q_neg_q, q_neg_d;   // quotient needs negation
    logic             r_neg_q, r_neg_d;   // remainder needs negation
    logic             dz_q, dz_d;
    logic [WIDTH:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_q, acc_d;       // Booth accumulator or partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;         // multiplier or dividend/quotient
    logic             qm1_q, qm1_d;       // Booth q(-1) bit
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Request decode
    logic             uns_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = bus.Unsgn;
`else
    assign uns_in = 1'b0;
`endif

    always_comb begin
        a_neg = ~uns_in & bus.A[WIDTH-1];
        b_neg = ~uns_in & bus.B[WIDTH-1];
        a_mag = a_neg ? ({WIDTH{1'b0}} - bus.A) : bus.A;
        b_mag = b_neg ? ({WIDTH{1'b0}} - bus.B) : bus.B;
    end

    // One iteration step of the operation in flight
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] mq_step;
    logic             qm1_step;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        sum      = acc_q;
        shifted  = '0;
        trial    = '0;
        acc_step = acc_q;
        mq_step  = mq_q;
        qm1_step = qm1_q;
        if (!op_q) begin
            if (uns_q) begin
                // Plain shift-add; acc[WIDTH] catches the carry
                if (mq_q[0]) begin
                    sum = acc_q + mcand_q;
                end
                acc_step = {1'b0, sum[WIDTH:1]};
            end else begin
                case ({mq_q[0], qm1_q})
                    2'b01:   sum = acc_q + mcand_q;
                    2'b10:   sum = acc_q - mcand_q;
                    default: sum = acc_q;
                endcase
                // Extra accumulator bit keeps -2^(W-1) multiplicands from overflowing
                acc_step = {sum[WIDTH], sum[WIDTH:1]};
            end
            mq_step  = {sum[0], mq_q[WIDTH-1:1]};
            qm1_step = mq_q[0];
        end else begin
            shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
            // Two guard bits: an unsigned divisor may use the full width
            trial   = {1'b0, shifted} - {1'b0, mcand_q};
            if (!trial[WIDTH+1]) begin
                acc_step = trial[WIDTH:0];
                mq_step  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = shifted;
                mq_step  = {mq_q[WIDTH-2:0], 1'b0};
            end
            qm1_step = 1'b0;
        end
    end

    always_comb begin
        quo = mq_step;
        rem = acc_step[WIDTH-1:0];
        if (!op_q) begin
            res_hi = acc_step[WIDTH-1:0];
            res_lo = mq_step;
        end else begin
            res_hi = r_neg_q ? ({WIDTH{1'b0}} - rem) : rem;
            res_lo = q_neg_q ? ({WIDTH{1'b0}} - quo) : quo;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        uns_d   = uns_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    op_d    = bus.Op;
                    uns_d   = uns_in;
                    cnt_d   = CntW'(WIDTH);
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    dz_d    = 1'b0;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    state_d = StRun;
                    if (bus.Op) begin
                        mcand_d = {1'b0, b_mag};
                        mq_d    = a_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        if (bus.B == '0) begin
                            dz_d    = 1'b1;
                            state_d = StFinish;
                        end
                    end else begin
                        mcand_d = {(~uns_in & bus.A[WIDTH-1]), bus.A};
                        mq_d    = bus.B;
                    end
                end
            end
            StRun: begin
                acc_d = acc_step;
                mq_d  = mq_step;
                qm1_d = qm1_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    // Result registers load as FINISH is entered so Hi/Lo are
                    // already valid during the Done cycle
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = StFinish;
                end
            end
            StFinish: begin
                dz_d    = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            uns_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            uns_q   <= uns_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        bus.Hi      = hi_q;
        bus.Lo      = lo_q;
        bus.Busy    = (state_q != StIdle);
        bus.Done    = (state_q == StFinish);
        bus.DivZero = (state_q == StFinish) & dz_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench: the driver computes each expected result with plain
// integer arithmetic and queues it; a monitor on the falling edge pops and
// compares whenever Done is seen, and otherwise checks that Hi/Lo hold.
// Honours MULTDIV_UNSIGNED_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;
    logic [31:0] mon_hi;
    logic [31:0] mon_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference behaviour: plain 64-bit integer arithmetic
    function automatic void ref_model(input logic op, input logic uns,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dz);
        logic [63:0] p;
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] pq;
        logic [63:0] pr;
        dz = 1'b0;
        hi = model_hi;
        lo = model_lo;
        if (!op) begin
            if (uns) begin
                p = {32'h0, a} * {32'h0, b};
            end else begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            dz = 1'b1;
        end else if (uns) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            pq = sq;
            pr = sr;
            lo = pq[31:0];
            hi = pr[31:0];
        end
    endfunction

    task automatic set_uns(input logic uns);
`ifdef MULTDIV_UNSIGNED_EN
        bus.Unsgn = uns;
`else
        if (uns) fail_now("unsigned_requested_without_feature");
`endif
    endtask

    // Called at posedge+2; returns at posedge+2 of the first idle cycle.
    task automatic issue(input logic op, input logic uns,
                         input logic [31:0] a, input logic [31:0] b,
                         input int repulse_at, input int reset_at);
        exp_t        e;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        bit          ended;
        ref_model(op, uns, a, b, hi, lo, dz);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        set_uns(uns);
        e.hi    = hi;
        e.lo    = lo;
        e.dz    = dz;
        e.lat   = dz ? 1 : int'(W) + 1;
        e.issue = cyc;
        exp_q.push_back(e);
        model_hi = hi;
        model_lo = lo;
        ended = 1'b0;
        for (int k = 1; k <= int'(W) + 10; k++) begin
            @(posedge clk);
            #2;
            if (k == 1) check32("busy_after_start", 32'(bus.Busy), 32'd1);
            if (k > 1 && !bus.Busy) begin
                ended = 1'b1;
                break;
            end
            // Inputs wander while busy; only the repulse cycle raises Start
            bus.Start = (k == repulse_at);
            bus.Op    = 1'($urandom);
            bus.A     = $urandom;
            bus.B     = $urandom;
`ifdef MULTDIV_UNSIGNED_EN
            bus.Unsgn = 1'($urandom);
`endif
            if (k == reset_at) begin
                rst       = 1'b1;
                bus.Start = 1'b1;
                e         = exp_q.pop_back();
                model_hi  = 32'h0;
                model_lo  = 32'h0;
            end
        end
        rst       = 1'b0;
        bus.Start = 1'b0;
        if (!ended) fail_now("busy_timeout");
        if (reset_at > 0) begin
            check32("abort_busy", 32'(bus.Busy), 32'd0);
            check32("abort_hi", bus.Hi, 32'h0);
            check32("abort_lo", bus.Lo, 32'h0);
            // Quiet window: any Done now would hit an empty scoreboard
            repeat (W + 5) @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    initial begin
        exp_t e;
        mon_hi = 32'h0;
        mon_lo = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_hi = 32'h0;
                mon_lo = 32'h0;
            end else if (bus.Done) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check32("result_hi", bus.Hi, e.hi);
                    check32("result_lo", bus.Lo, e.lo);
                    check32("divzero", 32'(bus.DivZero), 32'(e.dz));
                    check32("latency", 32'(cyc - e.issue), 32'(e.lat));
                    mon_hi = e.hi;
                    mon_lo = e.lo;
                end
            end else begin
                check32("divzero_without_done", 32'(bus.DivZero), 32'd0);
                check32("hold_hi", bus.Hi, mon_hi);
                check32("hold_lo", bus.Lo, mon_lo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic op;
        logic uns;
        logic [31:0] a;
        logic [31:0] b;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Op    = 1'b0;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
`ifdef MULTDIV_UNSIGNED_EN
        bus.Unsgn = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check32("reset_busy", 32'(bus.Busy), 32'd0);
        check32("reset_done", 32'(bus.Done), 32'd0);
        check32("reset_divzero", 32'(bus.DivZero), 32'd0);
        check32("reset_hi", bus.Hi, 32'h0);
        check32("reset_lo", bus.Lo, 32'h0);

        issue(1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0);
        issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        issue(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 0, 0);
        issue(1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFF3, 0, 0);
        issue(1'b0, 1'b0, $urandom, $urandom, 10, 0);
        issue(1'b0, 1'b0, $urandom, $urandom, 0, 20);
`ifdef MULTDIV_UNSIGNED_EN
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
`endif

        for (int i = 0; i < 48; i++) begin
            op = 1'($urandom);
            a  = pick();
            b  = pick();
`ifdef MULTDIV_UNSIGNED_EN
            uns = 1'($urandom);
`else
            uns = 1'b0;
`endif
            issue(op, uns, a, b, (i % 7 == 3) ? 5 : 0, 0);
        end

        repeat (4) @(posedge clk);
        #2;
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
